// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: digit-select codes,
// active-low anode patterns and display widths.
package ssd_pkg;

    localparam int DIGIT_W = 4;
    localparam int DISP_W  = 16;
    localparam int NUM_DIG = DISP_W / DIGIT_W;

    // Digit-select codes; the scan walks downwards from d1 to d4 and wraps.
    localparam logic [1:0] CTRL_D1 = 2'b11;
    localparam logic [1:0] CTRL_D2 = 2'b10;
    localparam logic [1:0] CTRL_D3 = 2'b01;
    localparam logic [1:0] CTRL_D4 = 2'b00;

    localparam logic [NUM_DIG-1:0] AN_D1  = 4'b0111;
    localparam logic [NUM_DIG-1:0] AN_D2  = 4'b1011;
    localparam logic [NUM_DIG-1:0] AN_D3  = 4'b1101;
    localparam logic [NUM_DIG-1:0] AN_D4  = 4'b1110;
    localparam logic [NUM_DIG-1:0] AN_OFF = 4'b1111;

    function automatic logic [NUM_DIG-1:0] an_for_ctrl(input logic [1:0] ctrl);
        logic [NUM_DIG-1:0] an;
        unique case (ctrl)
            CTRL_D1: an = AN_D1;
            CTRL_D2: an = AN_D2;
            CTRL_D3: an = AN_D3;
            default: an = AN_D4;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Display-side bundle of the scan controller: load strobe and value in,
// active digits, digit select, anodes and status out.
interface ssd_scan_ctrl_if;
    import ssd_pkg::*;

    logic [DISP_W-1:0]  DATA_IN;
    logic               LOAD;
    logic [DISP_W-1:0]  DIGITS;
    logic [1:0]         CONTROL;
    logic [NUM_DIG-1:0] AN;
    logic               PENDING;
    logic               FRAME_TICK;

    modport master (
        output DATA_IN, LOAD,
        input  DIGITS, CONTROL, AN, PENDING, FRAME_TICK
    );

    modport slave (
        input  DATA_IN, LOAD,
        output DIGITS, CONTROL, AN, PENDING, FRAME_TICK
    );

endinterface

// File: rtl/ssd_prescaler.sv
// Slot timer: counts CLK cycles per digit slot and tracks the blanking window
// at the start of each slot. PRESCALE >= 2 and BLANK_CYCLES < PRESCALE.
module ssd_prescaler #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic CLK,
    input  logic RST,
    output logic slot_end_o,
    output logic blank_next_o
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] blank_q, blank_d;

    assign slot_end_o = (cnt_q == CNT_W'(PRESCALE - 1));

    // blank_q holds the blanking cycles still owed in the current slot,
    // counting the present one; it reloads on the edge that starts a slot.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        blank_d = blank_q;
        if (slot_end_o) begin
            cnt_d   = '0;
            blank_d = BLK_W'(BLANK_CYCLES);
        end else if (blank_q != '0) begin
            blank_d = blank_q - BLK_W'(1);
        end
    end

    // The parent registers AN, so it needs the blanking state of the next cycle.
    assign blank_next_o = (blank_d != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            blank_q <= BLK_W'(BLANK_CYCLES);
        end else begin
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller with anode blanking and a
// frame-synchronous double buffer. Optional: SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_ctrl #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic           CLK,
    input  logic           RST,
    ssd_scan_ctrl_if.slave bus_if
);
    import ssd_pkg::*;

    logic                slot_end;
    logic                blank_next;
    logic                frame_end;
    logic                slot_shown;

    logic [1:0]          ctrl_q,    ctrl_d;
    logic [NUM_DIG-1:0]  an_q,      an_d;
    logic [DISP_W-1:0]   digits_q,  digits_d;
    logic [DISP_W-1:0]   buf_q,     buf_d;
    logic                pending_q, pending_d;
    logic                tick_q,    tick_d;

    ssd_prescaler #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .CLK          (CLK),
        .RST          (RST),
        .slot_end_o   (slot_end),
        .blank_next_o (blank_next)
    );

    // The last d4 cycle: CONTROL wraps to d1 and a new frame starts.
    assign frame_end = slot_end && (ctrl_q == CTRL_D4);

    always_comb begin
        ctrl_d    = ctrl_q;
        digits_d  = digits_q;
        buf_d     = buf_q;
        pending_d = pending_q;
        tick_d    = frame_end;
        if (slot_end) begin
            ctrl_d = ctrl_q - 2'd1;
        end
        if (frame_end && pending_q) begin
            digits_d  = buf_q;
            pending_d = 1'b0;
        end
        // A LOAD coinciding with the boundary refills the buffer just emptied.
        if (bus_if.LOAD) begin
            buf_d     = bus_if.DATA_IN;
            pending_d = 1'b1;
        end
    end

    // Anodes are decided from next-state values so the registered AN lines up
    // with CONTROL and DIGITS on the same cycle.
    always_comb begin
        slot_shown = 1'b1;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        unique case (ctrl_d)
            CTRL_D1: slot_shown = |digits_d[15:12];
            CTRL_D2: slot_shown = |digits_d[15:8];
            CTRL_D3: slot_shown = |digits_d[15:4];
            default: slot_shown = 1'b1;
        endcase
`endif
        an_d = (blank_next || !slot_shown) ? AN_OFF : an_for_ctrl(ctrl_d);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_q    <= CTRL_D1;
            an_q      <= AN_OFF;
            digits_q  <= '0;
            buf_q     <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            an_q      <= an_d;
            digits_q  <= digits_d;
            buf_q     <= buf_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
        end
    end

    assign bus_if.CONTROL    = ctrl_q;
    assign bus_if.AN         = an_q;
    assign bus_if.DIGITS     = digits_q;
    assign bus_if.PENDING    = pending_q;
    assign bus_if.FRAME_TICK = tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with PRESCALE=8, BLANK_CYCLES=2.
module tb_ssd_scan_ctrl;
    import ssd_pkg::*;

    localparam int PS    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * PS;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    ssd_scan_ctrl_if bus ();

    ssd_scan_ctrl #(
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .bus_if (bus)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] m_digits = '0;
    logic [15:0] m_buf    = '0;
    logic        m_pend   = 1'b0;
    logic        saw_aaaa = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_ctrl(input int c);
        return 2'(3 - ((c / PS) % 4));
    endfunction

    function automatic logic [3:0] exp_an(input int c, input logic [15:0] dig);
        logic [1:0] ct;
        logic       shown;
        ct    = exp_ctrl(c);
        shown = 1'b1;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (ct == 2'b11) shown = (dig[15:12] != 4'h0);
        if (ct == 2'b10) shown = (dig[15:8]  != 8'h00);
        if (ct == 2'b01) shown = (dig[15:4]  != 12'h000);
`else
        shown = shown | (dig == 16'hFFFF);
`endif
        if ((c % PS) < BC || !shown) return 4'b1111;
        case (ct)
            2'b11:   return 4'b0111;
            2'b10:   return 4'b1011;
            2'b01:   return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic check_scan();
        check($sformatf("control@%0d", cyc), bus.CONTROL, exp_ctrl(cyc));
        check($sformatf("an@%0d", cyc), bus.AN, exp_an(cyc, m_digits));
        check($sformatf("tick@%0d", cyc), bus.FRAME_TICK, (cyc > 0 && cyc % FRAME == 0));
        check($sformatf("digits@%0d", cyc), bus.DIGITS, m_digits);
        check($sformatf("pending@%0d", cyc), bus.PENDING, m_pend);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (cyc % FRAME == 0 && m_pend) begin
            m_digits = m_buf;
            m_pend   = 1'b0;
        end
        if (bus.LOAD) begin
            m_buf  = bus.DATA_IN;
            m_pend = 1'b1;
        end
        if (bus.DIGITS == 16'hAAAA) saw_aaaa = 1'b1;
        check_scan();
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic load(input logic [15:0] val);
        bus.DATA_IN = val;
        bus.LOAD    = 1'b1;
        step();
        bus.LOAD    = 1'b0;
        bus.DATA_IN = '0;
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        cyc      = 0;
        m_digits = '0;
        m_buf    = '0;
        m_pend   = 1'b0;
        check_scan();
    endtask

    initial begin
        bus.DATA_IN = '0;
        bus.LOAD    = 1'b0;

        // Reset held across clock edges.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_an", bus.AN, 4'b1111);
        check("rst_control", bus.CONTROL, 2'b11);
        check("rst_digits", bus.DIGITS, 16'h0000);
        check("rst_pending", bus.PENDING, 1'b0);
        check("rst_tick", bus.FRAME_TICK, 1'b0);

        // Free-running scan, two frames.
        release_reset();
        advance_to(1);
        check("blank_c1", bus.AN, 4'b1111);
        advance_to(2);
        check("d1_on_c2", bus.AN, 4'b0111);
        advance_to(64);

        // Single LOAD mid-frame.
        advance_to(70);
        load(16'h1234);
        check("s2_pending", bus.PENDING, 1'b1);
        check("s2_digits_hold", bus.DIGITS, 16'h0000);
        advance_to(95);
        check("s2_before_edge", bus.DIGITS, 16'h0000);
        step();
        check("s2_digits", bus.DIGITS, 16'h1234);
        check("s2_pend_clr", bus.PENDING, 1'b0);
        check("s2_tick", bus.FRAME_TICK, 1'b1);

        // Two LOADs in one frame: last wins.
        advance_to(100);
        load(16'hAAAA);
        advance_to(110);
        load(16'h5555);
        advance_to(128);
        check("s3_digits", bus.DIGITS, 16'h5555);
        check("s3_no_aaaa", saw_aaaa, 1'b0);

        // LOAD on the boundary edge with a value already pending.
        advance_to(140);
        load(16'h1111);
        advance_to(159);
        load(16'hBEEF);
        check("s4_digits", bus.DIGITS, 16'h1111);
        check("s4_pending", bus.PENDING, 1'b1);
        advance_to(192);
        check("s4_next", bus.DIGITS, 16'hBEEF);

        // Asynchronous reset mid-slot with a value pending.
        advance_to(195);
        load(16'h7777);
        advance_to(212);
        check("s5_pre_ctrl", bus.CONTROL, 2'b01);
        check("s5_pre_pend", bus.PENDING, 1'b1);
        #3;
        RST = 1'b1;
        #1;
        check("s5_async_an", bus.AN, 4'b1111);
        check("s5_async_ctrl", bus.CONTROL, 2'b11);
        check("s5_async_pend", bus.PENDING, 1'b0);
        check("s5_async_digits", bus.DIGITS, 16'h0000);
        release_reset();
        advance_to(2);
        check("s5_restart_an", bus.AN, 4'b0111);
        advance_to(32);
        check("s5_restart_tick", bus.FRAME_TICK, 1'b1);
        advance_to(64);

        // Values with leading zeros.
        load(16'h0050);
        advance_to(100);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        check("lz_d1", bus.AN, 4'b1111);
        advance_to(108);
        check("lz_d2", bus.AN, 4'b1111);
`else
        check("lz_d1", bus.AN, 4'b0111);
        advance_to(108);
        check("lz_d2", bus.AN, 4'b1011);
`endif
        advance_to(116);
        check("lz_d3", bus.AN, 4'b1101);
        advance_to(124);
        check("lz_d4", bus.AN, 4'b1110);
        load(16'h0000);
        advance_to(132);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        check("zero_d1", bus.AN, 4'b1111);
        advance_to(148);
        check("zero_d3", bus.AN, 4'b1111);
`else
        check("zero_d1", bus.AN, 4'b0111);
        advance_to(148);
        check("zero_d3", bus.AN, 4'b1101);
`endif
        advance_to(156);
        check("zero_d4", bus.AN, 4'b1110);
        advance_to(160);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
